divider_unit: RTL and testbench

//   Multi-cycle radix-2 restoring integer divider serving DIV/DIVU from stage_ex.

---
 rtl/divider_unit.sv | 161 ++++++++++++++++
 tb/tb_divider_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: quotient on o_result_lo,
// remainder on o_result_hi, one quotient bit per cycle, stall via o_busy.
module divider_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_signed_div,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_result_lo,
  output logic [WIDTH-1:0] o_result_hi
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_ZERO = 2'd1,
    S_RUNNING  = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_result_lo;
  logic [WIDTH-1:0] r_result_hi;
  logic [CW-1:0]    r_count;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_ready;

  logic             w_accept;
  logic             w_div_zero;
  logic [WIDTH:0]   w_partial;
  logic [WIDTH-1:0] w_diff;
  logic             w_neg;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x, input logic en);
    return (en && x[WIDTH-1]) ? f_neg(x) : x;
  endfunction

  assign w_div_zero = (i_divisor == {WIDTH{1'b0}});
  assign w_accept   = (r_state == S_IDLE) & i_start & ~i_cancel;

  // Trial subtract; the difference fits WIDTH bits whenever it is kept.
  assign w_partial  = {r_rem, r_quo[WIDTH-1]};
  assign w_neg      = (w_partial < {1'b0, r_dvs});
  assign w_diff     = w_partial[WIDTH-1:0] - r_dvs;
  assign w_rem_next = w_neg ? w_partial[WIDTH-1:0] : w_diff;
  assign w_quo_next = {r_quo[WIDTH-2:0], ~w_neg};

  // Stall starts combinationally in the issue cycle.
  assign o_busy      = ~i_reset & ((r_state == S_RUNNING) | (r_state == S_DIV_ZERO) | w_accept);
  assign o_ready     = r_ready;
  assign o_result_lo = r_result_lo;
  assign o_result_hi = r_result_hi;

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: cancel beats start, DONE always returns to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_cancel) begin
          w_next = S_IDLE;
        end else if (i_start) begin
          w_next = w_div_zero ? S_DIV_ZERO : S_RUNNING;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_DIV_ZERO: begin
        w_next = i_cancel ? S_IDLE : S_DONE;
      end
      S_RUNNING: begin
        if (i_cancel) begin
          w_next = S_IDLE;
        end else if (r_count == LAST) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RUNNING;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_quo       <= {WIDTH{1'b0}};
      r_rem       <= {WIDTH{1'b0}};
      r_dvs       <= {WIDTH{1'b0}};
      r_result_lo <= {WIDTH{1'b0}};
      r_result_hi <= {WIDTH{1'b0}};
      r_count     <= {CW{1'b0}};
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (!i_cancel) begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_rem   <= {WIDTH{1'b0}};
              r_count <= {CW{1'b0}};
              r_dvs   <= f_abs(i_divisor, i_signed_div);
              r_q_neg <= i_signed_div & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
              r_r_neg <= i_signed_div & i_dividend[WIDTH-1];
              // A zero divisor reports the raw dividend, so keep it unmodified.
              r_quo   <= w_div_zero ? i_dividend : f_abs(i_dividend, i_signed_div);
            end
          end
          S_DIV_ZERO: begin
            r_result_lo <= {WIDTH{1'b1}};
            r_result_hi <= r_quo;
            r_ready     <= 1'b1;
          end
          S_RUNNING: begin
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            r_count <= r_count + CW'(1);
            if (r_count == LAST) begin
              r_result_lo <= r_q_neg ? f_neg(w_quo_next) : w_quo_next;
              r_result_hi <= r_r_neg ? f_neg(w_rem_next) : w_rem_next;
              r_ready     <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit: expected results are queued at issue and
// compared with immediate assertions when ready is observed.
module tb_divider_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         signed_div;
  logic         cancel;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         ready;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  divider_unit #(.WIDTH(W)) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_start      (start),
    .i_signed_div (signed_div),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .i_cancel     (cancel),
    .o_busy       (busy),
    .o_ready      (ready),
    .o_result_lo  (result_lo),
    .o_result_hi  (result_hi)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one divide, wait for ready, compare against the scoreboard entry.
  // With hold set, start is raised again during DONE and must be ignored.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo,
                         input logic [31:0] ehi, input int elat, input bit hold);
    exp_t e;
    int   cyc;
    bit   seen;
    bit   extra;
    e.lo = elo; e.hi = ehi; e.lat = elat;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b1; signed_div = sd; dividend = a; divisor = b;
    #1;
    check({tag, "_busy_issue"}, 32'(busy), 32'd1);
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clock);
      if (ready) begin
        seen = 1'b1;
      end else begin
        @(posedge clock);
        cyc++;
      end
    end
    check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    check({tag, "_lo"}, result_lo, e.lo);
    check({tag, "_hi"}, result_hi, e.hi);
    check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    if (hold) begin
      start = 1'b1; signed_div = 1'b0; dividend = 32'h5; divisor = 32'h0;
      @(posedge clock);
      #1 start = 1'b0;
    end
    @(negedge clock);
    check({tag, "_ready_pulse"}, 32'(ready), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    if (hold) begin
      extra = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        if (ready || busy) extra = 1'b1;
      end
      check({tag, "_start_in_done_ignored"}, 32'(extra), 32'd0);
      check({tag, "_hold_lo"}, result_lo, e.lo);
    end
  endtask

  initial begin
    logic [31:0] ra, rb, qe, re;
    logic        rs;
    bit          got;

    reset = 1'b1; start = 1'b1; cancel = 1'b1; signed_div = 1'b0;
    dividend = 32'd100; divisor = 32'd7;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_lo", result_lo, 32'd0);
    check("reset_hi", result_hi, 32'd0);
    reset = 1'b0; start = 1'b0; cancel = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, 1'b0);
    run_div("div_by0", 1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 2, 1'b0);
    run_div("divu_by0", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 2, 1'b0);
    run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33, 1'b0);
    run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33, 1'b0);

    // Cancel at iteration 10.
    @(negedge clock);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    cancel = 1'b1;
    @(posedge clock);
    #1 cancel = 1'b0;
    @(negedge clock);
    check("cancel_busy", 32'(busy), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ready) got = 1'b1;
    end
    check("cancel_no_ready", 32'(got), 32'd0);
    check("cancel_lo_kept", result_lo, 32'hFFFFFFFF);
    check("cancel_hi_kept", result_hi, 32'd0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b0);

    // Cancel and start together in IDLE: nothing starts.
    @(negedge clock);
    start = 1'b1; cancel = 1'b1; dividend = 32'd50; divisor = 32'd0;
    #1 check("cancel_start_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1 begin start = 1'b0; cancel = 1'b0; end
    got = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (ready || busy) got = 1'b1;
    end
    check("cancel_start_idle", 32'(got), 32'd0);

    // Reset at iteration 20, with start and cancel also asserted.
    @(negedge clock);
    start = 1'b1; signed_div = 1'b1; dividend = 32'hFFFF0000; divisor = 32'd17;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (20) @(posedge clock);
    @(negedge clock);
    reset = 1'b1; start = 1'b1; cancel = 1'b1;
    @(posedge clock);
    #1 begin reset = 1'b0; start = 1'b0; cancel = 1'b0; end
    @(negedge clock);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_ready", 32'(ready), 32'd0);
    check("midreset_lo", result_lo, 32'd0);
    check("midreset_hi", result_hi, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ready || busy) got = 1'b1;
    end
    check("midreset_idle", 32'(got), 32'd0);

    run_div("start_in_done", 1'b0, 32'd77, 32'd10, 32'd7, 32'd7, 33, 1'b1);

    // Back-to-back randomized divides against a behavioural model.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd5;
      rs = (i % 2 == 1);
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      if (rs) begin
        qe = $signed(ra) / $signed(rb);
        re = $signed(ra) % $signed(rb);
      end else begin
        qe = ra / rb;
        re = ra % rb;
      end
      run_div($sformatf("rand%0d", i), rs, ra, rb, qe, re, 33, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
